// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU result writeback path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hs_npu_pkg;

    typedef logic [31:0] uword;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_POP,
        WR_SEND,
        WR_DONE
    } writer_state_e;

endpackage

// File: rtl/hs_npu_result_writer_if.sv
// Lane FIFO source port plus addressed memory-write request channel.
// Latency: n/a (wires only).
// Backpressure: output_fifo_ready_o pops all lanes; mem_ready_i stalls beats.
interface hs_npu_result_writer_if #(
    parameter int SIZE      = 8,
    parameter int ACT_WIDTH = 16,
    parameter int BUS_WIDTH = 32
);
    logic [ACT_WIDTH-1:0]  inference_result_i  [SIZE];
    logic                  output_fifo_valid_i [SIZE];
    logic                  output_fifo_ready_o;
    logic                  mem_valid_o;
    hs_npu_pkg::uword      mem_addr_o;
    logic [BUS_WIDTH-1:0]  mem_data_o;
    logic                  mem_ready_i;

    // Writer side: consumes lane FIFOs, drives memory requests.
    modport master (
        input  inference_result_i,
        input  output_fifo_valid_i,
        output output_fifo_ready_o,
        output mem_valid_o,
        output mem_addr_o,
        output mem_data_o,
        input  mem_ready_i
    );

    // Environment side: lane FIFOs and memory/writeback master.
    modport slave (
        output inference_result_i,
        output output_fifo_valid_i,
        input  output_fifo_ready_o,
        input  mem_valid_o,
        input  mem_addr_o,
        input  mem_data_o,
        output mem_ready_i
    );
endinterface

// File: rtl/hs_npu_row_serializer.sv
// Holds one popped row and presents it as BUS_WIDTH beats, lane 0 in the LSBs of beat 0.
// Latency: data valid for beat 0 the cycle after load.
// Backpressure: beat index moves only on advance; data holds otherwise.
module hs_npu_row_serializer #(
    parameter int SIZE      = 8,
    parameter int ACT_WIDTH = 16,
    parameter int BUS_WIDTH = 32,
    parameter int BEATS     = SIZE * ACT_WIDTH / BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [ACT_WIDTH-1:0] lanes [SIZE],
    output logic                 last_beat,
    output logic [BUS_WIDTH-1:0] data
);
    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [SIZE*ACT_WIDTH-1:0] row_buf;
    logic [BCW-1:0]            beat_cnt;

    // Capture the whole row on load; step the beat index on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf  <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            for (int k = 0; k < SIZE; k++) begin
                row_buf[k*ACT_WIDTH +: ACT_WIDTH] <= lanes[k];
            end
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    assign last_beat = (beat_cnt == BCW'(BEATS - 1));

    // Beat mux over constant slices of the row buffer.
    always_comb begin
        data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BCW'(b)) begin
                data = row_buf[b*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end
endmodule

// File: rtl/hs_npu_result_writer.sv
// Pops full rows from the per-lane output FIFOs and writes them to memory as addressed beats.
// Latency: pop -> first beat 1 cycle; last beat accept -> next pop 1 cycle; BEATS+1 cycles/row.
// Backpressure: no pop until every lane is valid; mem_ready_i low holds the beat stable.
module hs_npu_result_writer
    import hs_npu_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int ACT_WIDTH = 16,
    parameter int BUS_WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start_i,
    input  uword  base_addr_i,
    input  uword  num_rows_i,
    input  uword  row_stride_i,
    output logic  busy_o,
    output logic  done_o,
    hs_npu_result_writer_if.master wr
);
    localparam int   BEATS      = SIZE * ACT_WIDTH / BUS_WIDTH;
    localparam uword BEAT_BYTES = uword'(BUS_WIDTH / 8);

    if (((SIZE * ACT_WIDTH) % BUS_WIDTH) != 0 || (BUS_WIDTH % 8) != 0) begin : g_bad_geometry
        $error("row width must be a whole number of byte-aligned beats");
    end

    writer_state_e        state;
    uword                 num_rows_q;
    uword                 row_stride_q;
    uword                 row_cnt;
    uword                 row_addr;
    uword                 beat_addr;
    logic                 busy_q;
    logic                 done_q;
    logic                 mem_valid_q;
    logic                 all_valid;
    logic                 pop;
    logic                 beat_acc;
    logic                 ser_last;
    logic [BUS_WIDTH-1:0] ser_data;

    // A row is only poppable when every lane FIFO has data.
    always_comb begin
        all_valid = 1'b1;
        for (int k = 0; k < SIZE; k++) begin
            all_valid = all_valid & wr.output_fifo_valid_i[k];
        end
    end

    assign pop      = (state == WR_POP) && all_valid;
    assign beat_acc = (state == WR_SEND) && wr.mem_ready_i;

    hs_npu_row_serializer #(
        .SIZE      (SIZE),
        .ACT_WIDTH (ACT_WIDTH),
        .BUS_WIDTH (BUS_WIDTH),
        .BEATS     (BEATS)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pop),
        .advance   (beat_acc),
        .lanes     (wr.inference_result_i),
        .last_beat (ser_last),
        .data      (ser_data)
    );

    // Control FSM: sequences pop/send per row, tracks row and beat addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WR_IDLE;
            num_rows_q   <= '0;
            row_stride_q <= '0;
            row_cnt      <= '0;
            row_addr     <= '0;
            beat_addr    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_valid_q  <= 1'b0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (num_rows_i != '0) begin
                            num_rows_q   <= num_rows_i;
                            row_stride_q <= row_stride_i;
                            row_cnt      <= '0;
                            row_addr     <= base_addr_i;
                            state        <= WR_POP;
                        end else begin
                            done_q <= 1'b1;
                            state  <= WR_DONE;
                        end
                    end
                end
                WR_POP: begin
                    if (pop) begin
                        beat_addr   <= row_addr;
                        mem_valid_q <= 1'b1;
                        state       <= WR_SEND;
                    end
                end
                WR_SEND: begin
                    if (wr.mem_ready_i) begin
                        if (ser_last) begin
                            mem_valid_q <= 1'b0;
                            row_cnt     <= row_cnt + 32'd1;
                            row_addr    <= row_addr + row_stride_q;
                            if (row_cnt + 32'd1 == num_rows_q) begin
                                done_q <= 1'b1;
                                state  <= WR_DONE;
                            end else begin
                                state <= WR_POP;
                            end
                        end else begin
                            beat_addr <= beat_addr + BEAT_BYTES;
                        end
                    end
                end
                WR_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= WR_IDLE;
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign wr.output_fifo_ready_o = pop;
    assign wr.mem_valid_o         = mem_valid_q;
    assign wr.mem_addr_o          = mem_valid_q ? beat_addr : '0;
    assign wr.mem_data_o          = mem_valid_q ? ser_data : '0;
endmodule

// File: tb/tb_hs_npu_result_writer.sv
// Bench for hs_npu_result_writer: table vectors, corner sequences, random transfers.
// Latency: checked from observed cycle indices.
// Backpressure: lane arrival and mem_ready_i driven by mode.
module tb_hs_npu_result_writer;
    import hs_npu_pkg::*;

    localparam int SIZE      = 8;
    localparam int ACT_WIDTH = 16;
    localparam int BUS_WIDTH = 32;
    localparam int BEATS     = SIZE * ACT_WIDTH / BUS_WIDTH;
    localparam int LPB       = BUS_WIDTH / ACT_WIDTH;
    localparam int MAXR      = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    uword base_addr, num_rows, row_stride;
    logic busy, done;

    hs_npu_result_writer_if #(.SIZE(SIZE), .ACT_WIDTH(ACT_WIDTH), .BUS_WIDTH(BUS_WIDTH)) bus ();

    hs_npu_result_writer #(.SIZE(SIZE), .ACT_WIDTH(ACT_WIDTH), .BUS_WIDTH(BUS_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .num_rows_i   (num_rows),
        .row_stride_i (row_stride),
        .busy_o       (busy),
        .done_o       (done),
        .wr           (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [ACT_WIDTH-1:0] rows [MAXR][SIZE];
    uword                 obs_addr [$];
    logic [BUS_WIDTH-1:0] obs_data [$];
    int pops, done_cnt, done_cyc, first_pop_cyc, first_beat_cyc, last_beat_cyc;
    int valid_cyc, stall_seen;

    typedef struct {
        uword base;
        uword stride;
        uword nrows;
        int   exp_beats;
        int   exp_pops;
        uword exp_last_addr;
        int   exp_done_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < MAXR; r++)
            for (int k = 0; k < SIZE; k++)
                rows[r][k] = 16'h1000 + 16'(r * 16'h100) + 16'(k);
    endtask

    task automatic fill_random();
        for (int r = 0; r < MAXR; r++)
            for (int k = 0; k < SIZE; k++)
                rows[r][k] = ACT_WIDTH'($urandom);
    endtask

    task automatic lanes_idle();
        for (int k = 0; k < SIZE; k++) begin
            bus.output_fifo_valid_i[k] = 1'b0;
            bus.inference_result_i[k]  = '0;
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 stall beat index 2 for 3 cycles.
    // vmode: 0 lanes valid when a row is available (last lane held off until lag),
    //        1 each lane arrives at a random cycle.
    // Called at posedge+1 with the DUT idle.
    task automatic run(input uword b, input uword s, input uword n, input int rmode,
                       input int vmode, input int lag, input bit restart, input int budget);
        logic lv [SIZE];
        int   popped, acc, stall_left, ready_viol, stab_viol;
        bit   fin, prev_hold;
        uword prev_addr;
        logic [BUS_WIDTH-1:0] prev_data;
        obs_addr.delete(); obs_data.delete();
        pops = 0; done_cnt = 0; done_cyc = -1; first_pop_cyc = -1; first_beat_cyc = -1;
        last_beat_cyc = -1; valid_cyc = 0; stall_seen = 0;
        popped = 0; acc = 0; stall_left = 3; ready_viol = 0; stab_viol = 0;
        fin = 0; prev_hold = 0; prev_addr = '0; prev_data = '0;
        for (int k = 0; k < SIZE; k++) lv[k] = 1'b0;
        base_addr = b; row_stride = s; num_rows = n;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            start = (cyc == 0) || (restart && cyc == 3);
            if (restart && cyc == 3) begin
                base_addr = 32'hDEAD0000; num_rows = 5; row_stride = 4;
            end
            for (int k = 0; k < SIZE; k++) begin
                bit have;
                have = popped < int'(n);
                if (vmode == 0) lv[k] = have && (k != SIZE - 1 || cyc >= lag);
                else if (!have) lv[k] = 1'b0;
                else if (!lv[k]) lv[k] = ($urandom_range(0, 3) != 0);
                bus.output_fifo_valid_i[k] = lv[k];
                bus.inference_result_i[k]  = have ? rows[popped][k] : '0;
            end
            if (rmode == 1) bus.mem_ready_i = 1'($urandom_range(0, 1));
            else            bus.mem_ready_i = 1'b1;
            @(negedge clk);
            if (rmode == 2) begin
                if (bus.mem_valid_o && acc == 2 && stall_left > 0) begin
                    bus.mem_ready_i = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    bus.mem_ready_i = 1'b1;
                end
            end
            if (bus.output_fifo_ready_o) begin
                bit allv;
                allv = 1'b1;
                for (int k = 0; k < SIZE; k++) allv = allv & lv[k];
                if (!allv) ready_viol++;
                pops++;
                popped++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                for (int k = 0; k < SIZE; k++) lv[k] = 1'b0;
            end
            if (prev_hold && (!bus.mem_valid_o || bus.mem_addr_o != prev_addr ||
                              bus.mem_data_o != prev_data)) stab_viol++;
            if (bus.mem_valid_o) begin
                valid_cyc++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (bus.mem_ready_i) begin
                    obs_addr.push_back(bus.mem_addr_o);
                    obs_data.push_back(bus.mem_data_o);
                    last_beat_cyc = cyc;
                    acc++;
                end
            end
            prev_hold = bus.mem_valid_o && !bus.mem_ready_i;
            prev_addr = bus.mem_addr_o;
            prev_data = bus.mem_data_o;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        lanes_idle();
        bus.mem_ready_i = 1'b1;
        if (!fin) chk("done_timeout", 64'd0, 64'd1);
        // Reference: row r, beat bi sits at base + r*stride + bi*bytes; lanes fill LSB-first.
        chk("beat_count", 64'(obs_addr.size()), 64'(n * BEATS));
        for (int i = 0; i < obs_addr.size() && i < int'(n) * BEATS; i++) begin
            int   r, bi;
            uword ea;
            logic [BUS_WIDTH-1:0] ed;
            r  = i / BEATS;
            bi = i % BEATS;
            ea = b + uword'(r) * s + uword'(bi * (BUS_WIDTH / 8));
            ed = '0;
            for (int j = 0; j < LPB; j++)
                ed = ed | (BUS_WIDTH'(rows[r][bi * LPB + j]) << (j * ACT_WIDTH));
            chk("beat_addr", 64'(obs_addr[i]), 64'(ea));
            chk("beat_data", 64'(obs_data[i]), 64'(ed));
        end
        chk("pop_count", 64'(pops), 64'(n));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("ready_without_all_valid", 64'(ready_viol), 64'd0);
        chk("stall_stability", 64'(stab_viol), 64'd0);
        if (fin && n != 0) begin
            chk("done_after_last_beat", 64'(done_cyc - last_beat_cyc), 64'd1);
            chk("pop_to_first_beat", 64'(first_beat_cyc - first_pop_cyc), 64'd1);
        end
        if (n == 0) chk("zero_rows_done_cycle", 64'(done_cyc), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_after_done", 64'(done), 64'd0);
        @(posedge clk); #1;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h0000_0100, 32'd16,         32'd1, 4,  1, 32'h0000_010C, 6};
        vecs[1] = '{32'h0000_2000, 32'h40,         32'd3, 12, 3, 32'h0000_208C, 16};
        vecs[2] = '{32'hFFFF_FFF8, 32'd0,          32'd1, 4,  1, 32'h0000_0004, 6};
        vecs[3] = '{32'h0000_1234, 32'd8,          32'd0, 0,  0, 32'h0000_0000, 1};
        vecs[4] = '{32'h0000_0010, 32'hFFFF_FFF0,  32'd2, 8,  2, 32'h0000_000C, 11};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; row_stride = '0;
        bus.mem_ready_i = 1'b1;
        lanes_idle();
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fifo_ready", 64'(bus.output_fifo_ready_o), 64'd0);
        chk("rst_mem_valid", 64'(bus.mem_valid_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_mem_data", 64'(bus.mem_data_o), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors, mem_ready held high, all lanes ready together.
        fill_pattern();
        for (int v = 0; v < 5; v++) begin
            run(vecs[v].base, vecs[v].stride, vecs[v].nrows, 0, 0, 0, 0, 200);
            chk("vec_beats", 64'(obs_addr.size()), 64'(vecs[v].exp_beats));
            chk("vec_pops", 64'(pops), 64'(vecs[v].exp_pops));
            chk("vec_valid_cycles", 64'(valid_cyc), 64'(vecs[v].exp_beats));
            chk("vec_done_cycle", 64'(done_cyc), 64'(vecs[v].exp_done_cyc));
            if (obs_addr.size() > 0)
                chk("vec_last_addr", 64'(obs_addr[obs_addr.size() - 1]), 64'(vecs[v].exp_last_addr));
            if (v == 0 && obs_data.size() == 4) begin
                chk("vec0_data0", 64'(obs_data[0]), 64'h1001_1000);
                chk("vec0_data1", 64'(obs_data[1]), 64'h1003_1002);
                chk("vec0_data2", 64'(obs_data[2]), 64'h1005_1004);
                chk("vec0_data3", 64'(obs_data[3]), 64'h1007_1006);
            end
        end

        // Last lane arrives 5 cycles after the block starts waiting.
        run(32'h400, 32'h10, 32'd1, 0, 0, 6, 0, 100);
        chk("lag_pop_cycle", 64'(first_pop_cyc), 64'd6);
        chk("lag_first_beat", 64'(first_beat_cyc), 64'd7);

        // Three-cycle stall on beat 2.
        run(32'h500, 32'h10, 32'd1, 2, 0, 0, 0, 100);
        chk("stall_cycles", 64'(stall_seen), 64'd3);
        chk("stall_valid_cycles", 64'(valid_cyc), 64'(BEATS + 3));

        // Second start while busy must not disturb the transfer.
        run(32'h600, 32'h20, 32'd2, 0, 0, 0, 1, 100);
        begin
            int extra;
            extra = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (bus.mem_valid_o || busy) extra++;
            end
            chk("restart_ignored_idle", 64'(extra), 64'd0);
            @(posedge clk); #1;
        end

        // Reset asserted while a beat is pending.
        for (int k = 0; k < SIZE; k++) begin
            bus.output_fifo_valid_i[k] = 1'b1;
            bus.inference_result_i[k]  = rows[0][k];
        end
        bus.mem_ready_i = 1'b0;
        base_addr = 32'h300; num_rows = 2; row_stride = 32'h20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                seen = bus.mem_valid_o;
            end
            chk("rst_mid_send_reached", 64'(seen), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_valid", 64'(bus.mem_valid_o), 64'd0);
        chk("rst_mid_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_mid_mem_data", 64'(bus.mem_data_o), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_fifo_ready", 64'(bus.output_fifo_ready_o), 64'd0);
        lanes_idle();
        bus.mem_ready_i = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Random transfers against the reference.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run(uword'($urandom), uword'($urandom), uword'($urandom_range(1, 4)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 0, 400);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
